// File: rtl/prim_rr_sched.sv
// prim_rr_sched: round-robin scheduler that shares one registered output
// channel among N requesters using a valid/ready handshake.
// Optional feature: define PRIM_RR_SCHED_LOCK_EN to add lock_i. When lock_i is
// set, the last winner keeps the channel while it continues to request.
module prim_rr_sched #(
  parameter  int N    = 4,
  parameter  int DW   = 32,
  localparam int IdxW = (N == 1) ? 1 : $clog2(N)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [N-1:0]    req_i,
  input  logic [N*DW-1:0] data_i,
  output logic [N-1:0]    gnt_o,
  output logic            valid_o,
  output logic [DW-1:0]   data_o,
  output logic [IdxW-1:0] idx_o,
`ifdef PRIM_RR_SCHED_LOCK_EN
  input  logic [N-1:0]    lock_i,
`endif
  input  logic            ready_i
);

  logic            valid_q, valid_d;
  logic [DW-1:0]   data_q, data_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [IdxW-1:0] ptr_q, ptr_d;

  logic            free;
  logic            any_req;
  logic            grant_en;
  logic            lock_hit;
  logic [IdxW-1:0] rr_win;
  logic [IdxW-1:0] win;

  // Round-robin search: the first requester at or after ptr_q, wrapping at N.
  // Offsets are walked from the far end so the nearest one is assigned last.
  always_comb begin
    logic [IdxW-1:0] pos;
    rr_win = ptr_q;
    pos    = ptr_q;
    for (int i = N - 1; i >= 0; i--) begin
      pos = IdxW'((int'(ptr_q) + i) % N);
      if (req_i[pos]) begin
        rr_win = pos;
      end else begin
        rr_win = rr_win;
      end
    end
  end

  // Pick the winner, drive the grant and compute the next register state.
  always_comb begin
    free    = !valid_q || ready_i;
    any_req = |req_i;
`ifdef PRIM_RR_SCHED_LOCK_EN
    // A lock holds only while the last winner's beat is still registered.
    // An idle cycle clears valid_q, and that breaks the lock.
    lock_hit = valid_q && req_i[idx_q] && lock_i[idx_q];
`else
    lock_hit = 1'b0;
`endif
    win      = lock_hit ? idx_q : rr_win;
    // Gate with rst_ni so that no grant (and no payload capture) is
    // signalled while reset is held.
    grant_en = rst_ni && free && any_req;

    gnt_o   = '0;
    valid_d = valid_q;
    data_d  = data_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;

    if (grant_en) begin
      gnt_o[win] = 1'b1;
      data_d     = data_i[int'(win) * DW +: DW];
      idx_d      = win;
      valid_d    = 1'b1;
      if (lock_hit) begin
        ptr_d = ptr_q;
      end else if (win == IdxW'(N - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = win + IdxW'(1);
      end
    end else if (free) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Output register and round-robin pointer, cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign idx_o   = idx_q;

endmodule
